// File: rtl/add_16_rr_sched_if.sv
// Bundle between add_16_rr_sched and its environment: the requester-side
// handshake and operands, the operand/result path to the shared adder, and
// the tagged response stream.
//   req/a_bus/b_bus/c_in_bus : per-requester request lines and packed operands
//   gnt                      : one-hot combinational grant
//   add_a/add_b/add_c_in     : operand mux into the external adder
//   add_sum/add_c_out        : adder result, valid lat edges after capture
//   rsp_*                    : registered result strobe, owner id and data
//   in_flight                : operations issued but not yet returned
// The slave modport is the scheduler's view; master is the environment's.
interface add_16_rr_sched_if #(
  parameter int size  = 16,
  parameter int n_req = 4,
  parameter int id_w  = 2
);
  logic [n_req-1:0]      req;
  logic [n_req*size-1:0] a_bus;
  logic [n_req*size-1:0] b_bus;
  logic [n_req-1:0]      c_in_bus;
  logic [n_req-1:0]      gnt;
  logic [size-1:0]       add_a;
  logic [size-1:0]       add_b;
  logic                  add_c_in;
  logic [size-1:0]       add_sum;
  logic                  add_c_out;
  logic                  rsp_valid;
  logic [id_w-1:0]       rsp_id;
  logic [size-1:0]       rsp_sum;
  logic                  rsp_c_out;
  logic [2:0]            in_flight;

  modport slave (
    input  req, a_bus, b_bus, c_in_bus, add_sum, add_c_out,
    output gnt, add_a, add_b, add_c_in,
           rsp_valid, rsp_id, rsp_sum, rsp_c_out, in_flight
  );

  modport master (
    output req, a_bus, b_bus, c_in_bus, add_sum, add_c_out,
    input  gnt, add_a, add_b, add_c_in,
           rsp_valid, rsp_id, rsp_sum, rsp_c_out, in_flight
  );
endinterface

// File: rtl/add_16_rr_sched.sv
// Round-robin scheduler sharing one pipelined adder among n_req requesters.
// Arbitrates requests with a rotating priority pointer, muxes the winner's
// operands into the adder, carries a {valid, id} tag alongside the adder's
// lat-stage pipeline and registers each returning result with its owner id.
// 2**id_w must be at least n_req.
//   clock : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : add_16_rr_sched_if slave modport (requests, adder path, responses)
module add_16_rr_sched #(
  parameter int size  = 16,
  parameter int n_req = 4,
  parameter int id_w  = 2,
  parameter int lat   = 3
) (
  input  logic clock,
  input  logic reset,
  add_16_rr_sched_if.slave bus
);

  logic [id_w-1:0] ptr;
  logic [id_w-1:0] cand;
  logic [id_w-1:0] gnt_idx;
  logic            found;
  logic [n_req-1:0] gnt;

  logic [size-1:0] a_arr [n_req];
  logic [size-1:0] b_arr [n_req];

  logic            tag_v  [lat];
  logic [id_w-1:0] tag_id [lat];

  logic            rsp_valid;
  logic [id_w-1:0] rsp_id;
  logic [size-1:0] rsp_sum;
  logic            rsp_c_out;
  logic [2:0]      in_flight;

  for (genvar g = 0; g < n_req; g++) begin : g_unpack
    assign a_arr[g] = bus.a_bus[g*size +: size];
    assign b_arr[g] = bus.b_bus[g*size +: size];
  end

  // Walk the requesters starting at ptr; the first one asserting req wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < n_req; k++) begin
      cand = id_w'((int'(ptr) + k) % n_req);
      if (!found && bus.req[cand]) begin
        found       = 1'b1;
        gnt[cand]   = 1'b1;
        gnt_idx     = cand;
      end
    end
  end

  assign bus.gnt      = gnt;
  assign bus.add_a    = found ? a_arr[gnt_idx] : '0;
  assign bus.add_b    = found ? b_arr[gnt_idx] : '0;
  assign bus.add_c_in = found ? bus.c_in_bus[gnt_idx] : 1'b0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt_idx == id_w'(n_req - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Tag travels in lockstep with the operands through the adder pipeline.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < lat; i++) begin
        tag_v[i]  <= 1'b0;
        tag_id[i] <= '0;
      end
    end else begin
      tag_v[0]  <= found;
      tag_id[0] <= gnt_idx;
      for (int i = 1; i < lat; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_c_out <= 1'b0;
    end else begin
      rsp_valid <= tag_v[lat-1];
      if (tag_v[lat-1]) begin
        rsp_id    <= tag_id[lat-1];
        rsp_sum   <= bus.add_sum;
        rsp_c_out <= bus.add_c_out;
      end
    end
  end

  // Issue and return on the same edge cancel out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_flight <= '0;
    end else begin
      in_flight <= in_flight + 3'(found) - 3'(tag_v[lat-1]);
    end
  end

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_sum   = rsp_sum;
  assign bus.rsp_c_out = rsp_c_out;
  assign bus.in_flight = in_flight;

endmodule
